sp_ram_banked: RTL and testbench
================================

Name: sp_ram_banked

Overview:
- Parametrised successor to the single-SPRAM data memory: gangs BANKS ice40up5k SPRAM blocks into one word-addressed memory.
- Adds a registered ack handshake, a registered byte-lane write path and an idle-driven standby power manager.
- Sits on the SoC data bus (cyc/we/sel/addr/wdata/rdata) behind the bus decoder, replacing the plain RAM slave.

Parameters:
- BANKS, 4: number of SPRAM banks; power of two, 1..4.
- BANK_WORDS, 16384: 32-bit words per bank; power of two.
- IDLE_CYCLES, 64: consecutive idle READY cycles before entering standby; 0 disables standby.
- WAKE_CYCLES, 3: cycles held in WAKE after standby release before an access is accepted; minimum 1.

Ports:
- ck  in  1  system clock; all state on rising edge
- rst  in  1  synchronous, active-high reset
- cyc  in  1  bus cycle request, held until ack
- we  in  1  1 = write, 0 = read
- sel  in  4  byte-lane enables, bit n = wdata[8n+7:8n]
- addr  in  32  byte address; bits [1:0] and bits above the memory range ignored
- wdata  in  32  write data
- rdata  out  32  read data; valid only while ack=1, otherwise 0
- ack  out  1  one-cycle completion pulse
- standby  out  1  1 while banks are in standby (status/LED)

Behaviour:
- Address: word = addr[WA+1:2], WA = log2(BANKS*BANK_WORDS). bank = word[WA-1:WA-BB], BB = log2(BANKS) (bank 0 when BANKS=1). offset = word[WA-BB-1:0]. Higher address bits alias.
- FSM states: READY, SLEEP, WAKE. Reset gives READY, ack=0, rdata=0, standby=0, idle counter 0, wake counter 0.
- Accept condition: state==READY & cyc & !ack.
- On accept, only the selected bank sees address and enable.
  - Write: wen = sel to that bank that cycle; memory updates at that edge.
  - Read: wen = 0.
  - bank index is registered.
- ack = 1 in the cycle after accept; rdata = registered bank's read data during that cycle.
- No accept while ack=1, so a held cyc costs a minimum of 2 cycles per access. A new access is accepted in the cycle after ack if cyc is still high.
- Writes with sel=0 are accepted and acked with no memory change.
- Banks not selected receive wen=0. Their contents hold in all states.
- Idle counter (READY only):
  - Clears when cyc=1 or ack=1; otherwise increments.
  - If IDLE_CYCLES>0 and the counter reaches IDLE_CYCLES-1 while idle, next state is SLEEP.
  - Counter saturates; no wrap.
- SLEEP: standby=1; all bank standby inputs asserted; no bank enables. cyc=1 moves to WAKE next cycle.
- WAKE:
  - standby=0; wake counter loads 0 on entry.
  - Go to READY when the counter reaches WAKE_CYCLES-1. cyc is ignored here.
  - The request is accepted in the first READY cycle if cyc is still high.
  - Wake latency: cyc rising in SLEEP at cycle t gives ack at t+WAKE_CYCLES+2.
- cyc dropped during WAKE: still completes WAKE into READY; idle counting restarts from 0.
- cyc dropped in the accept cycle (protocol violation): the access still completes and ack still pulses.
- Reset mid-access:
  - A write whose enable edge has already occurred stays in memory.
  - ack is forced to 0 in the reset cycle.
  - FSM returns to READY with standby=0 after reset.
- Reset does not clear memory contents.

Decomposition:
- Shared package sp_ram_pkg holds:
  - state encoding constants (READY/SLEEP/WAKE);
  - a clog2 function for WA/BB;
  - default IDLE_CYCLES and WAKE_CYCLES.
- One sub-module sp_ram_bank: wraps ice40up5k_spram with ports ck, cs, wen[3:0], addr, wdata, rdata, standby.
  - wen is gated by cs & !standby.
  - Instantiated BANKS times in a generate loop.
- Top level holds the FSM, counters, decode, ack register and read mux.

Test Plan:
- Write/read with BANKS=4, IDLE_CYCLES=0, after reset.
  - Stimulus: write 0xDEADBEEF, sel=4'hF to addr 0x0000_0010, then read addr 0x10.
  - Required: ack exactly 1 cycle after each accept; rdata=0xDEADBEEF only on the ack cycle, 0 otherwise.
- Byte lanes.
  - Stimulus: write 0x11223344 sel=F, then write 0xAABBCCDD sel=4'b0101 to the same address, then read.
  - Required: rdata=0x11BB33DD.
- Bank decode with BANK_WORDS=16384.
  - Stimulus: write 0x1 at word 0 and 0x2 at word 16384 (addr 0x10000), then read both.
  - Required: reads return 0x1 and 0x2; addr 0x40000 aliases word 0.
- Standby, IDLE_CYCLES=8, WAKE_CYCLES=3.
  - Stimulus: idle for 8 cycles, then read.
  - Required: standby=1 after the 8th idle cycle; ack at t+5 from cyc rise; data intact across standby.
- Back-to-back with cyc held high across two requests.
  - Required: ack pattern 0,1,0,1 (two accepts, 2-cycle spacing); no duplicate write.
- Reset mid-operation.
  - Stimulus: assert rst in the ack cycle, and separately during WAKE.
  - Required: ack=0, standby=0, state READY next cycle; a prior completed write still readable.

Source files
------------

// File: rtl/sp_ram_pkg.sv
// sp_ram_pkg: shared definitions for the banked SPRAM data memory.
//   state_e          - power-manager FSM encoding (ready / sleep / wake)
//   clog2()          - ceiling log2, used to size word, bank and offset fields
//   DefIdleCycles    - default idle READY cycles before standby
//   DefWakeCycles    - default cycles spent in WAKE after leaving standby
package sp_ram_pkg;

  typedef enum logic [1:0] {
    StReady = 2'd0,
    StSleep = 2'd1,
    StWake  = 2'd2
  } state_e;

  localparam int unsigned DefIdleCycles = 64;
  localparam int unsigned DefWakeCycles = 3;

  // Smallest r with 2**r >= v (clog2(1) = 0).
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((33'd1 << i) < {1'b0, v}) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/ice40up5k_spram.sv
// ice40up5k_spram: behavioural model of one 32-bit wide SPRAM block.
//   ck      - clock, all activity on rising edge
//   cs      - chip select; no access when low
//   wen     - per-byte write enables; all zero means read
//   addr    - word address
//   wdata   - write data
//   rdata   - registered read data, updated only by reads
//   standby - low-power retention; blocks all accesses
module ice40up5k_spram
  import sp_ram_pkg::*;
#(
  parameter int unsigned Words = 16384,
  localparam int unsigned AddrW = clog2(Words)
) (
  input  logic             ck,
  input  logic             cs,
  input  logic [3:0]       wen,
  input  logic [AddrW-1:0] addr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata,
  input  logic             standby
);

  logic [31:0] mem [Words];

  always_ff @(posedge ck) begin
    if (cs && !standby) begin
      if (wen == 4'b0000) begin
        rdata <= mem[addr];
      end else begin
        for (int i = 0; i < 4; i++) begin
          if (wen[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/sp_ram_bank.sv
// sp_ram_bank: one bank of the banked memory, wrapping a single SPRAM block.
//   ck      - clock
//   cs      - bank selected for this cycle's access
//   wen     - byte write enables (ignored unless cs and not in standby)
//   addr    - word offset within the bank
//   wdata   - write data
//   rdata   - registered read data from the SPRAM
//   standby - retention mode request
module sp_ram_bank
  import sp_ram_pkg::*;
#(
  parameter int unsigned Words = 16384,
  localparam int unsigned AddrW = clog2(Words)
) (
  input  logic             ck,
  input  logic             cs,
  input  logic [3:0]       wen,
  input  logic [AddrW-1:0] addr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata,
  input  logic             standby
);

  logic       cs_gated;
  logic [3:0] wen_gated;

  // A bank in standby must never see a write, even if cs glitches high.
  assign cs_gated  = cs & ~standby;
  assign wen_gated = cs_gated ? wen : 4'b0000;

  ice40up5k_spram #(
    .Words(Words)
  ) u_spram (
    .ck     (ck),
    .cs     (cs_gated),
    .wen    (wen_gated),
    .addr   (addr),
    .wdata  (wdata),
    .rdata  (rdata),
    .standby(standby)
  );

endmodule

// File: rtl/sp_ram_banked.sv
// sp_ram_banked: word-addressed data memory built from BANKS SPRAM banks, with a
// registered ack handshake and an idle-driven standby power manager.
//   ck      - system clock
//   rst     - synchronous active-high reset (memory contents are kept)
//   cyc     - bus cycle request, held until ack
//   we      - 1 = write, 0 = read
//   sel     - byte-lane enables for writes
//   addr    - byte address; [1:0] and bits above the memory range ignored
//   wdata   - write data
//   rdata   - read data, valid only while ack = 1, otherwise 0
//   ack     - one-cycle completion pulse, the cycle after accept
//   standby - 1 while the banks are held in standby
module sp_ram_banked
  import sp_ram_pkg::*;
#(
  parameter int unsigned BANKS       = 4,
  parameter int unsigned BANK_WORDS  = 16384,
  parameter int unsigned IDLE_CYCLES = DefIdleCycles,
  parameter int unsigned WAKE_CYCLES = DefWakeCycles
) (
  input  logic        ck,
  input  logic        rst,
  input  logic        cyc,
  input  logic        we,
  input  logic [3:0]  sel,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ack,
  output logic        standby
);

  localparam int unsigned WA    = clog2(BANKS * BANK_WORDS);
  localparam int unsigned BB    = clog2(BANKS);
  localparam int unsigned OffW  = WA - BB;
  localparam int unsigned BankW = (BB == 0) ? 1 : BB;

  // Address decode
  logic [WA-1:0]    word;
  logic [BankW-1:0] bank_idx;
  logic [OffW-1:0]  offset;
  logic             unused_addr;

  assign word     = addr[WA+1:2];
  // Shifting by the full offset width yields bank 0 when BANKS = 1.
  assign bank_idx = BankW'(word >> OffW);
  assign offset   = word[OffW-1:0];
  assign unused_addr = ^addr;

  // State
  state_e           state_q, state_d;
  logic [31:0]      idle_cnt_q, idle_cnt_d;
  logic [31:0]      wake_cnt_q, wake_cnt_d;
  logic             ack_q, ack_d;
  logic [BankW-1:0] bank_q, bank_d;
  logic             standby_q, standby_d;

  logic accept;

  // No accept during reset, so a reset cycle never writes memory.
  assign accept = (state_q == StReady) & cyc & ~ack_q & ~rst;

  always_comb begin
    state_d    = state_q;
    idle_cnt_d = idle_cnt_q;
    wake_cnt_d = wake_cnt_q;
    ack_d      = accept;
    bank_d     = accept ? bank_idx : bank_q;

    unique case (state_q)
      StReady: begin
        if (cyc || ack_q) begin
          idle_cnt_d = '0;
        end else begin
          if (idle_cnt_q != '1) idle_cnt_d = idle_cnt_q + 32'd1;
          if ((IDLE_CYCLES != 0) && (idle_cnt_q == IDLE_CYCLES - 1)) begin
            state_d    = StSleep;
            idle_cnt_d = '0;
          end
        end
      end
      StSleep: begin
        idle_cnt_d = '0;
        if (cyc) begin
          state_d    = StWake;
          wake_cnt_d = '0;
        end
      end
      StWake: begin
        // cyc is ignored here; a still-pending request is taken in READY.
        idle_cnt_d = '0;
        if (wake_cnt_q == WAKE_CYCLES - 1) begin
          state_d = StReady;
        end else begin
          wake_cnt_d = wake_cnt_q + 32'd1;
        end
      end
      default: begin
        state_d = StReady;
      end
    endcase

    standby_d = (state_d == StSleep);
  end

  always_ff @(posedge ck) begin
    if (rst) begin
      state_q    <= StReady;
      idle_cnt_q <= '0;
      wake_cnt_q <= '0;
      ack_q      <= 1'b0;
      bank_q     <= '0;
      standby_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      idle_cnt_q <= idle_cnt_d;
      wake_cnt_q <= wake_cnt_d;
      ack_q      <= ack_d;
      bank_q     <= bank_d;
      standby_q  <= standby_d;
    end
  end

  // Banks
  logic [BANKS-1:0] bank_cs;
  logic [31:0]      bank_rdata [BANKS];
  logic             bank_standby;

  assign bank_standby = (state_q == StSleep);

  for (genvar b = 0; b < BANKS; b++) begin : g_bank
    logic [3:0] bank_wen;

    assign bank_cs[b] = accept & (bank_idx == BankW'(b));
    assign bank_wen   = (bank_cs[b] & we) ? sel : 4'b0000;

    sp_ram_bank #(
      .Words(BANK_WORDS)
    ) u_bank (
      .ck     (ck),
      .cs     (bank_cs[b]),
      .wen    (bank_wen),
      .addr   (offset),
      .wdata  (wdata),
      .rdata  (bank_rdata[b]),
      .standby(bank_standby)
    );
  end

  // Outputs; ack is masked in a reset cycle even if an access was in flight.
  assign ack     = ack_q & ~rst;
  assign rdata   = ack ? bank_rdata[bank_q] : 32'd0;
  assign standby = standby_q;

endmodule

// File: tb/tb_sp_ram_banked.sv
// tb_sp_ram_banked: directed stimulus against sp_ram_banked with a cycle-level
// behavioural model checked on every falling edge, plus literal expectations.
module tb_sp_ram_banked;

  localparam int unsigned Idle = 8;
  localparam int unsigned Wake = 3;

  logic        ck = 1'b0;
  logic        rst = 1'b1;
  logic        cyc = 1'b0;
  logic        we = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] rdata;
  logic        ack;
  logic        standby;

  int n_cmp = 0;
  int n_bad = 0;
  int cycle = 0;

  sp_ram_banked #(
    .BANKS      (4),
    .BANK_WORDS (16384),
    .IDLE_CYCLES(Idle),
    .WAKE_CYCLES(Wake)
  ) dut (
    .ck     (ck),
    .rst    (rst),
    .cyc    (cyc),
    .we     (we),
    .sel    (sel),
    .addr   (addr),
    .wdata  (wdata),
    .rdata  (rdata),
    .ack    (ack),
    .standby(standby)
  );

  always #5 ck = ~ck;
  always @(posedge ck) cycle <= cycle + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cycle);
    end
  endtask

  // Model: memory image, one pending response, and power status expressed as
  // "asleep" plus the number of wake cycles left before requests are taken.
  logic [31:0] mem [int];
  bit          m_pend = 1'b0;
  bit          m_read = 1'b0;
  logic [31:0] m_data = 32'd0;
  bit          m_asleep = 1'b0;
  int          m_wake_left = 0;
  int          m_idle = 0;
  bit          e_ack;
  int          m_w;
  logic [31:0] m_cur;

  always @(negedge ck) begin
    e_ack = m_pend && !rst;
    check("ack", 32'(ack), 32'(e_ack));
    check("standby", 32'(standby), 32'(m_asleep));
    if (!e_ack) check("rdata_quiet", rdata, 32'd0);
    else if (m_read) check("rdata", rdata, m_data);

    if (rst) begin
      m_pend = 1'b0; m_asleep = 1'b0; m_wake_left = 0; m_idle = 0;
    end else if (!m_asleep && m_wake_left == 0) begin
      if (cyc && !m_pend) begin
        m_w   = int'(addr[17:2]);
        m_cur = mem.exists(m_w) ? mem[m_w] : 32'd0;
        if (we) begin
          for (int i = 0; i < 4; i++) if (sel[i]) m_cur[8*i +: 8] = wdata[8*i +: 8];
          mem[m_w] = m_cur;
        end
        m_read = !we;
        m_data = m_cur;
        m_pend = 1'b1;
        m_idle = 0;
      end else begin
        if (cyc || m_pend) begin
          m_idle = 0;
        end else begin
          m_idle++;
          if (m_idle == Idle) begin
            m_asleep = 1'b1;
            m_idle   = 0;
          end
        end
        m_pend = 1'b0;
      end
    end else if (m_asleep) begin
      if (cyc) begin
        m_asleep    = 1'b0;
        m_wake_left = Wake;
      end
    end else begin
      m_wake_left--;
      m_idle = 0;
    end
  end

  // Starts and ends just after a rising edge; lat = ack cycle - request cycle.
  task automatic access(input bit w, input logic [3:0] s, input logic [31:0] a,
                        input logic [31:0] d, output logic [31:0] rd, output int lat);
    int t0;
    bit got;
    t0 = cycle; got = 1'b0; rd = 32'd0; lat = -1;
    cyc = 1'b1; we = w; sel = s; addr = a; wdata = d;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge ck);
      if (ack) begin
        got = 1'b1; rd = rdata; lat = cycle - t0;
      end
      @(posedge ck); #1;
    end
    cyc = 1'b0; we = 1'b0;
    if (!got) begin
      n_cmp++; n_bad++;
      $display("FAIL access_timeout: got no ack expected ack for addr %h", a);
    end
  endtask

  initial begin
    logic [31:0] rd;
    int          lat;
    logic [3:0]  pat;

    repeat (3) @(posedge ck);
    #1 rst = 1'b0;

    // Basic write/read
    access(1'b1, 4'hF, 32'h10, 32'hDEADBEEF, rd, lat);
    check("wr_latency", 32'(lat), 32'd1);
    access(1'b0, 4'hF, 32'h10, 32'd0, rd, lat);
    check("rd_latency", 32'(lat), 32'd1);
    check("rd_deadbeef", rd, 32'hDEADBEEF);

    // Byte lanes
    access(1'b1, 4'hF, 32'h20, 32'h11223344, rd, lat);
    access(1'b1, 4'b0101, 32'h20, 32'hAABBCCDD, rd, lat);
    access(1'b0, 4'hF, 32'h20, 32'd0, rd, lat);
    check("byte_lanes", rd, 32'h11BB33DD);

    // Bank decode and aliasing
    access(1'b1, 4'hF, 32'h0, 32'h1, rd, lat);
    access(1'b1, 4'hF, 32'h10000, 32'h2, rd, lat);
    access(1'b0, 4'hF, 32'h0, 32'd0, rd, lat);
    check("bank0_word0", rd, 32'h1);
    access(1'b0, 4'hF, 32'h10000, 32'd0, rd, lat);
    check("bank1_word0", rd, 32'h2);
    access(1'b0, 4'hF, 32'h40000, 32'd0, rd, lat);
    check("alias_word0", rd, 32'h1);

    // Back-to-back with cyc held high
    cyc = 1'b1; we = 1'b1; sel = 4'hF; addr = 32'h30; wdata = 32'hA5A5A5A5;
    @(negedge ck); pat[3] = ack; @(posedge ck); #1;
    @(negedge ck); pat[2] = ack; @(posedge ck); #1;
    addr = 32'h34; wdata = 32'h5A5A5A5A;
    @(negedge ck); pat[1] = ack; @(posedge ck); #1;
    @(negedge ck); pat[0] = ack; @(posedge ck); #1;
    cyc = 1'b0; we = 1'b0;
    check("b2b_ack_pattern", 32'(pat), 32'(4'b0101));
    access(1'b1, 4'h0, 32'h30, 32'hFFFFFFFF, rd, lat);
    check("sel0_latency", 32'(lat), 32'd1);
    access(1'b0, 4'hF, 32'h30, 32'd0, rd, lat);
    check("b2b_first", rd, 32'hA5A5A5A5);
    access(1'b0, 4'hF, 32'h34, 32'd0, rd, lat);
    check("b2b_second", rd, 32'h5A5A5A5A);

    // Standby entry after 8 idle cycles, wake latency, data retention
    repeat (8) @(negedge ck);
    check("standby_before", 32'(standby), 32'd0);
    @(negedge ck);
    check("standby_after", 32'(standby), 32'd1);
    @(posedge ck); #1;
    access(1'b0, 4'hF, 32'h10, 32'd0, rd, lat);
    check("wake_latency", 32'(lat), 32'(Wake + 2));
    check("wake_data", rd, 32'hDEADBEEF);

    // Reset in the ack cycle of a write
    cyc = 1'b1; we = 1'b1; sel = 4'hF; addr = 32'h40; wdata = 32'hCAFEF00D;
    @(posedge ck); #1;
    rst = 1'b1; cyc = 1'b0; we = 1'b0;
    @(negedge ck);
    check("rst_ack_masked", 32'(ack), 32'd0);
    @(posedge ck); #1;
    rst = 1'b0;
    @(negedge ck);
    check("rst_ack_after", 32'(ack), 32'd0);
    check("rst_standby_after", 32'(standby), 32'd0);
    @(posedge ck); #1;
    access(1'b0, 4'hF, 32'h40, 32'd0, rd, lat);
    check("rst_ready_latency", 32'(lat), 32'd1);
    check("rst_write_kept", rd, 32'hCAFEF00D);

    // Reset during WAKE
    repeat (10) @(posedge ck);
    #1;
    check("sleep_again", 32'(standby), 32'd1);
    cyc = 1'b1; we = 1'b0; addr = 32'h40;
    @(posedge ck); #1;
    cyc = 1'b0;
    @(posedge ck); #1;
    rst = 1'b1;
    @(posedge ck); #1;
    rst = 1'b0;
    @(negedge ck);
    check("wake_rst_standby", 32'(standby), 32'd0);
    @(posedge ck); #1;
    access(1'b0, 4'hF, 32'h40, 32'd0, rd, lat);
    check("wake_rst_latency", 32'(lat), 32'd1);
    check("wake_rst_data", rd, 32'hCAFEF00D);

    repeat (3) @(posedge ck);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
